// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: widths, bubble instruction and fetch FSM states.
package riscv_pkg;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned INST_W = 32;

    // addi x0,x0,0
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to a variable-latency
// instruction memory, and feeds IF/ID with fetched instructions or NOP bubbles.
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 8'h00,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   pc4_out,
    output logic              inst_valid
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_inc;
    logic [INST_W-1:0] buf_q, buf_d;
    logic              req;
    logic              deliver;
    logic [INST_W-1:0] deliver_inst;

    assign pc_inc = pc_q + PC_W'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        req          = 1'b0;
        deliver      = 1'b0;
        deliver_inst = NOP_INST;

        unique case (state_q)
            REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect) begin
                    // A response still in flight must be swallowed before the next request.
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    deliver      = 1'b1;
                    deliver_inst = imem_rdata;
                    if (stall) begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = REQ;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    buf_d   = '0;
                    state_d = REQ;
                end else begin
                    deliver      = 1'b1;
                    deliver_inst = buf_q;
                    if (!stall) begin
                        pc_d    = pc_inc;
                        state_d = REQ;
                    end
                end
            end

            DROP: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end

            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Reset overrides outputs combinationally so the reset cycle itself already shows RESET_PC.
    assign imem_req   = req & ~rst;
    assign imem_addr  = pc_q;
    assign inst_valid = deliver & ~rst;
    assign inst_out   = (deliver && !rst) ? deliver_inst : NOP_INST;
    assign pc_out     = rst ? RESET_PC : pc_q;
    assign pc4_out    = rst ? RESET_PC + PC_W'(4) : pc_inc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a latency-programmable memory plus a transaction-level
// reference model (outstanding/stale/held flags) predicting every cycle's outputs.
module tb_if_fetch_stage;
    import riscv_pkg::*;

    localparam logic [7:0]  RST_PC = 8'h00;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_out;
    logic [7:0]  pc_out;
    logic [7:0]  pc4_out;
    logic        inst_valid;

    if_fetch_stage #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .pc4_out    (pc4_out),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // memory model
    logic [31:0] mem [64];
    int unsigned lat = 1;
    bit          rand_lat = 0;
    bit          mem_pend = 0;
    int unsigned mem_cnt = 0;
    logic [7:0]  mem_addr = '0;

    // reference model: transaction-level view of the fetch stage
    logic [7:0]  m_pc = RST_PC;
    bit          m_busy = 0;   // live request outstanding
    bit          m_stale = 0;  // outstanding request whose data must be thrown away
    bit          m_held = 0;   // fetched instruction parked while stalled
    logic [31:0] m_buf = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic run_cycle(input bit r, input bit s, input bit rd, input logic [7:0] rpc);
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_req;
        logic [7:0]  e_pc;
        logic [7:0]  e_pc4;
        bit          adv;

        @(negedge clk);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (r) begin
            mem_pend = 0;
        end else if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[mem_addr[7:2]];
                mem_pend    = 0;
            end
        end
        #1;

        if (r) begin
            e_req = 0; e_valid = 0; e_inst = NOP; e_pc = RST_PC;
        end else begin
            e_req   = !m_busy && !m_stale && !m_held && !rd;
            e_valid = !rd && (m_held || (m_busy && imem_rvalid));
            e_inst  = !e_valid ? NOP : (m_held ? m_buf : imem_rdata);
            e_pc    = m_pc;
        end
        e_pc4 = e_pc + 8'd4;

        check("imem_req",   {31'b0, imem_req},   {31'b0, e_req});
        check("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        check("inst_out",   inst_out,            e_inst);
        check("pc_out",     {24'b0, pc_out},     {24'b0, e_pc});
        check("pc4_out",    {24'b0, pc4_out},    {24'b0, e_pc4});
        if (!r) check("imem_addr", {24'b0, imem_addr}, {24'b0, m_pc});

        if (imem_req && !r) begin
            mem_pend = 1;
            mem_cnt  = rand_lat ? $urandom_range(1, 4) : lat;
            mem_addr = imem_addr;
        end

        if (r) begin
            m_pc = RST_PC; m_busy = 0; m_stale = 0; m_held = 0; m_buf = '0;
        end else if (rd) begin
            m_stale = (m_busy || m_stale) && !imem_rvalid;
            m_busy  = 0;
            m_held  = 0;
            m_pc    = rpc;
        end else begin
            adv = 0;
            if (m_held && !s) begin
                m_held = 0;
                adv    = 1;
            end else if (m_busy && imem_rvalid) begin
                m_busy = 0;
                if (s) begin
                    m_held = 1;
                    m_buf  = imem_rdata;
                end else begin
                    adv = 1;
                end
            end else if (m_stale && imem_rvalid) begin
                m_stale = 0;
            end
            if (e_req) m_busy = 1;
            if (adv) m_pc = m_pc + 8'd4;
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) run_cycle(0, 0, 0, 8'h00);
    endtask

    initial begin
        for (int unsigned i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'hAAAA_0001;
        mem[1]  = 32'hBBBB_0002;
        mem[63] = 32'hFCFC_003F;

        // latency 1: alternating request / delivery with bubbles
        lat = 1;
        run_cycle(1, 0, 0, 8'h00);
        run_cycle(1, 0, 0, 8'h00);
        idle(8);

        // latency 3, stall held four cycles from the response
        run_cycle(1, 0, 0, 8'h00);
        lat = 3;
        idle(3);
        for (int unsigned i = 0; i < 4; i++) run_cycle(0, 1, 0, 8'h00);
        idle(6);

        // redirect while waiting, stale response follows
        run_cycle(1, 0, 0, 8'h00);
        run_cycle(0, 0, 0, 8'h00);
        run_cycle(0, 0, 1, 8'h40);
        idle(8);

        // redirect coincident with response
        run_cycle(1, 0, 0, 8'h00);
        lat = 2;
        run_cycle(0, 0, 0, 8'h00);
        run_cycle(0, 0, 0, 8'h00);
        run_cycle(0, 0, 1, 8'h20);
        idle(6);

        // PC wrap from 0xFC
        run_cycle(1, 0, 0, 8'h00);
        lat = 1;
        run_cycle(0, 0, 1, 8'hFC);
        idle(6);

        // reset while holding, and reset while a response is pending
        run_cycle(1, 0, 0, 8'h00);
        run_cycle(0, 0, 0, 8'h00);
        run_cycle(0, 1, 0, 8'h00);
        run_cycle(0, 1, 0, 8'h00);
        run_cycle(1, 1, 0, 8'h00);
        idle(4);
        lat = 3;
        run_cycle(0, 0, 0, 8'h00);
        run_cycle(1, 0, 0, 8'h00);
        idle(8);

        // randomized traffic
        rand_lat = 1;
        for (int unsigned i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 99) < 2),
                      ($urandom_range(0, 99) < 35),
                      ($urandom_range(0, 99) < 10),
                      8'($urandom_range(0, 63) << 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
